// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op and state encodings for the multiply/divide unit
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2,
    MDS_FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - restoring unsigned divider, one quotient bit per step
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // The shifted remainder needs one extra bit; only the low bits survive a successful subtract.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, dsr});
    trial  = rem_sh[WIDTH-1:0] - dsr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
      cnt <= '0;
    end else if (step) begin
      rem <= fits ? trial : rem_sh[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
      cnt <= cnt + 1'b1;
    end
  end

  assign last = step && (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative mult/multu/div/divu unit holding the HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  md_state_t state, state_nxt;

  logic             busy, div_load, div_step, div_last;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             sign_a, sign_b, b_zero, done_q;
  logic [WIDTH-1:0] a_abs, b_abs, quo, rem, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod;
  logic             is_signed_div;

  always_ff @(posedge clk) begin
    if (rst) state <= MDS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDS_IDLE: if (bus.start) state_nxt = bus.op[1] ? MDS_DIV : MDS_MUL;
      MDS_MUL:  state_nxt = MDS_IDLE;
      MDS_DIV:  if (div_last) state_nxt = MDS_FIX;
      MDS_FIX:  state_nxt = MDS_IDLE;
      default:  state_nxt = MDS_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != MDS_IDLE);
    div_load = (state == MDS_IDLE) && bus.start && bus.op[1];
    div_step = (state == MDS_DIV);
  end

  // Signed divide runs on magnitudes; the sign bits are restored in FIX.
  always_comb begin
    is_signed_div = (bus.op == MD_DIV);
    a_abs = (is_signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs = (is_signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo      (quo),
    .rem      (rem),
    .last     (div_last)
  );

  always_comb begin
    if (op_q == MD_MULT)
      prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    else
      prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  // A zero divisor keeps the all-ones quotient regardless of the dividend's sign.
  always_comb begin
    quo_fix = quo;
    rem_fix = rem;
    if (op_q == MD_DIV) begin
      if ((sign_a ^ sign_b) && !b_zero) quo_fix = -quo;
      if (sign_a)                       rem_fix = -rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == MDS_MUL) || (state == MDS_FIX);
      if (state == MDS_IDLE && bus.start) begin
        op_q   <= bus.op;
        a_q    <= bus.a;
        b_q    <= bus.b;
        sign_a <= bus.a[WIDTH-1];
        sign_b <= bus.b[WIDTH-1];
        b_zero <= (bus.b == '0);
      end
      if (state == MDS_MUL) begin
        hi_q <= prod[2*WIDTH-1:WIDTH];
        lo_q <= prod[WIDTH-1:0];
      end else if (state == MDS_FIX) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for the multiply/divide unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp;
    longint unsigned ux, uy, up;
    int qi, ri;
    case (o)
      2'b00: begin sx = $signed(x); sy = $signed(y); sp = sx * sy; return sp; end
      2'b01: begin ux = x; uy = y; up = ux * uy; return up; end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {ri, qi};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [63:0] exp_v;
    if (!rst && bus.done === 1'b1) begin
      done_seen++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, required no done pulse", bus.hi, bus.lo);
      end else begin
        exp_v = sb.pop_front();
        if ({bus.hi, bus.lo} !== exp_v) begin
          miscompares++;
          $display("FAIL result: got hi=%h lo=%h, required hi=%h lo=%h",
                   bus.hi, bus.lo, exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int cyc = 0;
    int busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if (cyc != exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, exp_lat);
    end
    vectors++;
    if (busy_cnt != exp_lat) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_cnt, exp_lat);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_at_done: got %b, required 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, required all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    issue(2'b00, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", 1);
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 1);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 1);
    @(negedge clk);
  endtask

  task automatic test_div();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 33);
    issue(2'b11, 32'd100, 32'd7);
    wait_done("divu", 33);
    issue(2'b10, 32'd50, 32'hFFFF_FFFA);
    wait_done("div_negb", 33);
    @(negedge clk);
  endtask

  task automatic test_corner();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 33);
    issue(2'b11, 32'd5, 32'd0);
    wait_done("divu_zero", 33);
    issue(2'b10, 32'hFFFF_FFF0, 32'd0);
    wait_done("div_zero", 33);
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int base;
    base = done_seen;
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start", 22);
    repeat (5) @(negedge clk);
    vectors++;
    if (done_seen - base != 1) begin
      miscompares++;
      $display("FAIL busy_start_dones: got %0d done pulses, required 1", done_seen - base);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b11, 32'd1000, 32'd33);
    wait_done("b2b_divu", 33);
    issue(2'b01, 32'd3, 32'd4);
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd10, 32'd30}) begin
      miscompares++;
      $display("FAIL b2b_hold: got hi=%h lo=%h, required hi=0000000a lo=0000001e", bus.hi, bus.lo);
    end
    wait_done("b2b_multu", 1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    issue(2'b11, 32'hDEAD_BEEF, 32'd3);
    repeat (10) @(negedge clk);
    base = done_seen;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_mid_state: got busy=%b done=%b hi=%h lo=%h, required all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (done_seen != base) begin
      miscompares++;
      $display("FAIL reset_mid_done: got %0d done pulses, required 0", done_seen - base);
    end
    issue(2'b11, 32'd100, 32'd7);
    wait_done("after_reset", 33);
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    test_reset();
    test_mult();
    test_div();
    test_corner();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
